// File: rtl/game_flow_ctrl.sv
// Frogger game sequencer: tracks level and lives, walks the frame-paced
// death and level-up pauses, and drives freeze / respawn to the movers.
module game_flow_ctrl #(
  parameter int START_LIVES  = 3,
  parameter int MAX_LEVEL    = 9,
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       death_collision,
  input  logic       win_collision,
  output logic [3:0] current_level,
  output logic [1:0] lives,
  output logic       frog_respawn,
  output logic       freeze,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_DYING = 3'd2;
  localparam logic [2:0] S_LVLUP = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [3:0] LEVEL_TOP  = 4'(MAX_LEVEL);
  localparam logic [6:0] DEATH_LOAD = 7'(DEATH_FRAMES - 1);
  localparam logic [6:0] LEVEL_LOAD = 7'(LEVEL_FRAMES - 1);

  logic [6:0] timer;
  logic       start_prev;
  logic       start_edge;

  logic [2:0] state_n;
  logic [3:0] level_n;
  logic [1:0] lives_n;
  logic [6:0] timer_n;

  always_comb begin
    state_n    = state;
    level_n    = current_level;
    lives_n    = lives;
    timer_n    = timer;
    start_edge = start_btn & ~start_prev;
    case (state)
      S_IDLE, S_OVER: begin
        if (state == S_IDLE) level_n = 4'd0;
        if (start_edge) begin
          state_n = S_PLAY;
          lives_n = LIVES_INIT;
          level_n = 4'd1;
        end
      end
      S_PLAY: begin
        // Collisions only count on the frame boundary; death outranks win.
        if (frame_tick && death_collision) begin
          state_n = S_DYING;
          lives_n = lives - 2'd1;
          timer_n = DEATH_LOAD;
        end else if (frame_tick && win_collision) begin
          state_n = S_LVLUP;
          timer_n = LEVEL_LOAD;
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (timer != 7'd0) timer_n = timer - 7'd1;
          else               state_n = (lives == 2'd0) ? S_OVER : S_PLAY;
        end
      end
      S_LVLUP: begin
        if (frame_tick) begin
          if (timer != 7'd0) begin
            timer_n = timer - 7'd1;
          end else begin
            state_n = S_PLAY;
            level_n = (current_level >= LEVEL_TOP) ? LEVEL_TOP : current_level + 4'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        level_n = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      current_level <= 4'd0;
      lives         <= 2'd0;
      timer         <= 7'd0;
      start_prev    <= 1'b1;
      frog_respawn  <= 1'b0;
      freeze        <= 1'b1;
      game_over     <= 1'b0;
    end else begin
      state         <= state_n;
      current_level <= level_n;
      lives         <= lives_n;
      timer         <= timer_n;
      start_prev    <= start_btn;
      frog_respawn  <= (state_n == S_PLAY) && (state != S_PLAY);
      freeze        <= (state_n != S_PLAY);
      game_over     <= (state_n == S_OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a frame-counting model.
module tb_game_flow_ctrl;

  localparam int SL = 2;
  localparam int ML = 2;
  localparam int DF = 3;
  localparam int LF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       death_collision = 1'b0;
  logic       win_collision = 1'b0;
  logic [3:0] current_level;
  logic [1:0] lives;
  logic       frog_respawn;
  logic       freeze;
  logic       game_over;
  logic [2:0] state;

  game_flow_ctrl #(
    .START_LIVES(SL), .MAX_LEVEL(ML), .DEATH_FRAMES(DF), .LEVEL_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .death_collision(death_collision), .win_collision(win_collision),
    .current_level(current_level), .lives(lives), .frog_respawn(frog_respawn),
    .freeze(freeze), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode uses the externally visible state codes; dwell is counted
  // upward in frames seen rather than via a down-counting timer.
  int m_mode = 0, m_level = 0, m_lives = 0, m_frames = 0;
  int m_resp = 0, m_prev = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int edge_seen;
    if (reset) begin
      m_mode = 0; m_level = 0; m_lives = 0; m_frames = 0; m_resp = 0; m_prev = 1;
      return;
    end
    edge_seen = (start_btn && !m_prev) ? 1 : 0;
    m_prev = start_btn;
    m_resp = 0;
    case (m_mode)
      0, 4: if (edge_seen) begin
        m_mode = 1; m_lives = SL; m_level = 1; m_resp = 1;
      end
      1: if (frame_tick && death_collision) begin
        m_mode = 2; m_lives = m_lives - 1; m_frames = 0;
      end else if (frame_tick && win_collision) begin
        m_mode = 3; m_frames = 0;
      end
      2: if (frame_tick) begin
        m_frames++;
        if (m_frames == DF) begin
          if (m_lives == 0) m_mode = 4;
          else begin m_mode = 1; m_resp = 1; end
        end
      end
      3: if (frame_tick) begin
        m_frames++;
        if (m_frames == LF) begin
          m_level = (m_level + 1 > ML) ? ML : m_level + 1;
          m_mode = 1; m_resp = 1;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("state",        int'(state),         m_mode);
    chk("level",        int'(current_level), m_level);
    chk("lives",        int'(lives),         m_lives);
    chk("frog_respawn", int'(frog_respawn),  m_resp);
    chk("freeze",       int'(freeze),        (m_mode != 1) ? 1 : 0);
    chk("game_over",    int'(game_over),     (m_mode == 4) ? 1 : 0);
  endtask

  task automatic tick();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
  endtask

  task automatic press();
    start_btn = 1'b0; step(); start_btn = 1'b1; step(); start_btn = 1'b0;
  endtask

  initial begin
    // Reset with the start button held; holding it afterwards must not start.
    reset = 1'b1; start_btn = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    chk("lit_idle_state",  int'(state), 0);
    chk("lit_idle_level",  int'(current_level), 0);
    chk("lit_idle_freeze", int'(freeze), 1);

    press();
    chk("lit_start_state",   int'(state), 1);
    chk("lit_start_level",   int'(current_level), 1);
    chk("lit_start_lives",   int'(lives), SL);
    chk("lit_start_respawn", int'(frog_respawn), 1);
    step();
    chk("lit_respawn_once", int'(frog_respawn), 0);

    // Death held without a frame tick does nothing.
    death_collision = 1'b1;
    repeat (5) step();
    chk("lit_no_tick_death", int'(state), 1);
    tick();
    death_collision = 1'b0;
    chk("lit_dying_state",  int'(state), 2);
    chk("lit_dying_lives",  int'(lives), SL - 1);
    chk("lit_dying_freeze", int'(freeze), 1);
    repeat (DF - 1) begin step(); tick(); end
    chk("lit_dying_dwell", int'(state), 2);
    step(); tick();
    chk("lit_dying_exit",    int'(state), 1);
    chk("lit_dying_respawn", int'(frog_respawn), 1);

    // Two wins: second saturates at MAX_LEVEL.
    repeat (2) begin
      win_collision = 1'b1; tick(); win_collision = 1'b0;
      repeat (LF) begin step(); tick(); end
    end
    chk("lit_level_sat", int'(current_level), ML);
    chk("lit_level_play", int'(state), 1);

    // Simultaneous win and death: death wins, level untouched.
    win_collision = 1'b1; death_collision = 1'b1; tick();
    win_collision = 1'b0; death_collision = 1'b0;
    chk("lit_both_state", int'(state), 2);
    chk("lit_both_lives", int'(lives), 0);
    chk("lit_both_level", int'(current_level), ML);
    repeat (DF) tick();
    chk("lit_over_state", int'(state), 4);
    chk("lit_over_flag",  int'(game_over), 1);
    chk("lit_over_lives", int'(lives), 0);

    press();
    chk("lit_restart_lives", int'(lives), SL);
    chk("lit_restart_level", int'(current_level), 1);

    // Reset while the death timer is at 1.
    death_collision = 1'b1; tick(); death_collision = 1'b0;
    tick();
    reset = 1'b1; step(); reset = 1'b0;
    chk("lit_rst_state",   int'(state), 0);
    chk("lit_rst_respawn", int'(frog_respawn), 0);
    chk("lit_rst_freeze",  int'(freeze), 1);
    chk("lit_rst_lives",   int'(lives), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 299) == 0);
      frame_tick      = ($urandom_range(0, 3) == 0);
      death_collision = ($urandom_range(0, 9) == 0);
      win_collision   = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
